// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller
//   Four-phase signal controller (0 pedestrian, 1 up, 2 down, 3 turn) with sticky request
//   latching, round-robin phase selection, a minimum-green timer, rest-in-green and a fixed
//   all-red clearance interval between greens.
//
// Ports
//   clock            : rising-edge clock
//   reset            : asynchronous, active-high reset
//   pedestrian_req   : service request, phase 0 (level or pulse)
//   up_req           : service request, phase 1
//   down_req         : service request, phase 2
//   turn_req         : service request, phase 3
//   pedestrian_green : registered green, phase 0
//   up_green         : registered green, phase 1
//   down_green       : registered green, phase 2
//   turn_green       : registered green, phase 3
//   clearing         : high during the all-red clearance interval
//   pending[3:0]     : latched requests {turn, down, up, pedestrian}
module traffic_phase_controller #(
    parameter int unsigned MIN_GREEN    = 8,
    parameter int unsigned CLEAR_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pedestrian_req,
    input  logic       up_req,
    input  logic       down_req,
    input  logic       turn_req,
    output logic       pedestrian_green,
    output logic       up_green,
    output logic       down_green,
    output logic       turn_green,
    output logic       clearing,
    output logic [3:0] pending
);

    localparam logic [7:0] MinGreen = 8'(MIN_GREEN);
    localparam logic [7:0] ClearLen = 8'(CLEAR_CYCLES);

    typedef enum logic [1:0] {StIdle, StGreen, StClear} state_e;

    state_e     state;
    logic [1:0] phase;
    logic [7:0] green_cnt;
    logic [7:0] clear_cnt;
    logic [3:0] greens;
    // Set by reset: the very first search starts at phase 0 inclusive instead of phase+1.
    logic       search_from_zero;

    logic [3:0] req_vec;
    logic [3:0] pending_d;
    logic [3:0] drop_mask;
    logic [1:0] start;
    logic [1:0] cand;
    logic [1:0] winner;
    logic       found;
    logic       leave_clear;
    logic       enter_green;

    assign req_vec = {turn_req, down_req, up_req, pedestrian_req};

    // Round-robin search over the latched requests. Scanning the offsets from far to near
    // lets the nearest pending phase overwrite any farther one.
    always_comb begin
        start  = search_from_zero ? 2'd0 : phase + 2'd1;
        winner = start;
        found  = 1'b0;
        cand   = start;
        for (int i = 3; i >= 0; i--) begin
            cand = start + 2'(i);
            if (pending[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // A phase's request is consumed on the edge it turns green, and any request for the
    // phase currently showing green is discarded.
    always_comb begin
        leave_clear = (state == StClear) && (clear_cnt >= ClearLen);
        enter_green = found && ((state == StIdle) || leave_clear);
        drop_mask   = 4'b0000;
        if (state == StGreen) begin
            drop_mask[phase] = 1'b1;
        end
        if (enter_green) begin
            drop_mask[winner] = 1'b1;
        end
        pending_d = (pending | req_vec) & ~drop_mask;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= StIdle;
            phase            <= 2'd0;
            green_cnt        <= 8'd0;
            clear_cnt        <= 8'd0;
            greens           <= 4'b0000;
            clearing         <= 1'b0;
            pending          <= 4'b0000;
            search_from_zero <= 1'b1;
        end else begin
            pending <= pending_d;
            case (state)
                StIdle: begin
                    if (found) begin
                        state            <= StGreen;
                        phase            <= winner;
                        green_cnt        <= 8'd1;
                        greens           <= 4'b0001 << winner;
                        search_from_zero <= 1'b0;
                    end
                end
                StGreen: begin
                    if (green_cnt != 8'hFF) begin
                        green_cnt <= green_cnt + 8'd1;
                    end
                    // Rest in green until the minimum has elapsed and someone else waits.
                    if ((green_cnt >= MinGreen) && (pending != 4'b0000)) begin
                        state     <= StClear;
                        greens    <= 4'b0000;
                        clearing  <= 1'b1;
                        clear_cnt <= 8'd1;
                        green_cnt <= 8'd0;
                    end
                end
                StClear: begin
                    if (leave_clear) begin
                        clearing <= 1'b0;
                        if (found) begin
                            state     <= StGreen;
                            phase     <= winner;
                            green_cnt <= 8'd1;
                            greens    <= 4'b0001 << winner;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        clear_cnt <= clear_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= StIdle;
                    greens   <= 4'b0000;
                    clearing <= 1'b0;
                end
            endcase
        end
    end

    assign pedestrian_green = greens[0];
    assign up_green         = greens[1];
    assign down_green       = greens[2];
    assign turn_green       = greens[3];

    // Never more than one green, and never a green while clearing.
    a_greens_onehot0: assert property (@(posedge clock) disable iff (reset)
        $onehot0(greens) && !(clearing && (greens != 4'b0000)));

endmodule

// File: tb/tb_traffic_phase_controller.sv
module tb_traffic_phase_controller;

    localparam int MIN_G = 8;
    localparam int CLR   = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pedestrian_req = 1'b0;
    logic       up_req = 1'b0;
    logic       down_req = 1'b0;
    logic       turn_req = 1'b0;
    logic       pedestrian_green;
    logic       up_green;
    logic       down_green;
    logic       turn_green;
    logic       clearing;
    logic [3:0] pending;
    logic [3:0] greens;

    always #5 clock = ~clock;

    traffic_phase_controller #(
        .MIN_GREEN   (MIN_G),
        .CLEAR_CYCLES(CLR)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pedestrian_req  (pedestrian_req),
        .up_req          (up_req),
        .down_req        (down_req),
        .turn_req        (turn_req),
        .pedestrian_green(pedestrian_green),
        .up_green        (up_green),
        .down_green      (down_green),
        .turn_green      (turn_green),
        .clearing        (clearing),
        .pending         (pending)
    );

    assign greens = {turn_green, down_green, up_green, pedestrian_green};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (timeline view) ----------------
    // mode 0 idle, 1 green, 2 clear; m_since = edge number at which the mode was entered.
    bit [3:0] m_pend  = 4'b0;
    int       m_mode  = 0;
    int       m_phase = 0;
    bit       m_fresh = 1'b1;
    int       m_since = 0;

    typedef struct packed {
        int phase;
        int cycle;
    } ev_t;
    ev_t exp_q[$];

    // Nearest pending phase after 'last' (cyclic distance), or from phase 0 after reset.
    function automatic int rr_pick(input bit [3:0] p, input int last, input bit fresh);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = 99;
        for (int k = 0; k < 4; k++) begin
            d = fresh ? k : (k - last - 1 + 8) % 4;
            if (p[k] && d < bestd) begin
                bestd = d;
                best  = k;
            end
        end
        return best;
    endfunction

    always @(posedge clock) begin
        bit [3:0] seen;
        bit       was_green;
        int       old_phase;
        int       pick;
        cyc++;
        if (reset) begin
            m_pend  = 4'b0;
            m_mode  = 0;
            m_phase = 0;
            m_fresh = 1'b1;
        end else begin
            seen      = m_pend;
            was_green = (m_mode == 1);
            old_phase = m_phase;
            pick      = rr_pick(seen, m_phase, m_fresh);
            if (m_mode == 1) begin
                if (cyc - m_since >= MIN_G && seen != 4'b0) begin
                    m_mode  = 2;
                    m_since = cyc;
                end
            end else if (m_mode == 0 || cyc - m_since >= CLR) begin
                if (pick >= 0) begin
                    m_mode  = 1;
                    m_phase = pick;
                    m_since = cyc;
                    m_fresh = 1'b0;
                    exp_q.push_back('{phase: pick, cycle: cyc});
                end else begin
                    m_mode = 0;
                end
            end
            m_pend = seen | {turn_req, down_req, up_req, pedestrian_req};
            if (was_green) m_pend[old_phase] = 1'b0;
            if (m_mode == 1) m_pend[m_phase] = 1'b0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [3:0] prev_g = 4'b0;
    int         last_g = -1;
    bit [15:0]  pair_seen = 16'b0;

    always @(negedge clock) begin
        ev_t      ev;
        int       ph;
        bit [3:0] mg;
        mg = (m_mode == 1) ? (4'b0001 << m_phase) : 4'b0000;
        check("outputs_vs_model", {23'b0, greens, clearing, pending},
              {23'b0, mg, (m_mode == 2), m_pend});
        if (greens != prev_g && greens != 4'b0) begin
            ph = 0;
            for (int k = 0; k < 4; k++) if (greens[k]) ph = k;
            if (exp_q.size() == 0) begin
                check("unexpected_green", 32'(ph), 32'hFFFF_FFFF);
            end else begin
                ev = exp_q.pop_front();
                check("green_phase", 32'(ph), 32'(ev.phase));
                check("green_cycle", 32'(cyc), 32'(ev.cycle));
            end
            if (last_g >= 0 && last_g != ph) pair_seen[last_g * 4 + ph] = 1'b1;
            last_g = ph;
        end
        prev_g = greens;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_reqs(input logic [3:0] v);
        {turn_req, down_req, up_req, pedestrian_req} = v;
    endtask

    task automatic pulse(input logic [3:0] v);
        @(negedge clock);
        set_reqs(v);
        @(negedge clock);
        set_reqs(4'b0);
    endtask

    // Async reset between edges, with requests held high while in reset.
    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        set_reqs(4'hF);
        #1;
        check("async_reset", {23'b0, greens, clearing, pending}, 32'b0);
        exp_q.delete();
        last_g = -1;
        @(negedge clock);
        reset = 1'b0;
        set_reqs(4'h0);
    endtask

    task automatic wait_green(input int ph, input int budget);
        int n;
        n = 0;
        while (!greens[ph] && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!greens[ph]) begin
            errors++;
            $display("FAIL wait_green: phase %0d not green after %0d cycles, greens=%b",
                     ph, budget, greens);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int c;
        int n;
        int ph;
        int npairs;
        logic [3:0] v;

        // Reset state.
        @(negedge clock);
        check("reset_state", {23'b0, greens, clearing, pending}, 32'b0);
        reset = 1'b0;

        // Single up request rests in green.
        pulse(4'b0010);
        wait_green(1, 5);
        repeat (30) @(negedge clock);
        check("rest_in_green", {28'b0, greens}, 32'b0010);

        // Minimum green then clearance then turn.
        do_reset();
        pulse(4'b0001);
        wait_green(0, 5);
        g = 1;
        c = 0;
        n = 0;
        while (!turn_green && n < 40) begin
            @(negedge clock);
            set_reqs(n == 0 ? 4'b1000 : 4'b0000);
            n++;
            if (pedestrian_green) g++;
            if (clearing) c++;
        end
        check("min_green_len", 32'(g), 32'(MIN_G));
        check("clear_len", 32'(c), 32'(CLR));
        check("turn_after_clear", {31'b0, turn_green}, 32'b1);

        // All four at once, then wrap-around turn -> pedestrian.
        do_reset();
        pulse(4'b1111);
        wait_green(3, 80);
        pulse(4'b0001);
        wait_green(0, 30);

        // Reset mid-clear with up and down pending.
        do_reset();
        pulse(4'b0001);
        wait_green(0, 5);
        pulse(4'b0110);
        n = 0;
        while (!clearing && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("reached_clear", {31'b0, clearing}, 32'b1);
        do_reset();
        repeat (20) @(negedge clock);
        check("idle_after_reset", {24'b0, greens, pending}, 32'b0);

        // Random single-request episodes to exercise every ordered pair.
        for (int e = 0; e < 150; e++) begin
            ph = $urandom_range(0, 3);
            if (m_mode == 1 && m_phase == ph) ph = (ph + 1) % 4;
            pulse(4'b0001 << ph);
            wait_green(ph, 40);
        end

        // Random multi-request traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            for (int k = 0; k < 4; k++) v[k] = ($urandom_range(0, 7) == 0);
            set_reqs(v);
            if ($urandom_range(0, 399) == 0) do_reset();
        end
        set_reqs(4'b0);
        repeat (100) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        npairs = 0;
        for (int k = 0; k < 16; k++) if (pair_seen[k]) npairs++;
        check("pairs_covered", 32'(npairs), 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
